dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single-ported 12-bit/8-bit data memory between the execute unit (primary requester) and a debug/loader port (secondary requester). The block sits between the execute stage's memory control outputs and the data memory. It grants one access per cycle, with fixed CPU priority bounded by a starvation limit. It provides a debug lock mode that holds the memory for the debug port across multiple cycles, and it returns read data with a registered valid to the requester that issued the read.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles a pending debug request may lose to the CPU; legal range 1–15.
- ADDR_W, 12: memory address width.
- DATA_W, 8: memory data width.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset_  in  1  asynchronous, active-low reset.
- cpu_req / cpu_wr  in  1 / 1  CPU access request; write=1, read=0.
- cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address and write data.
- cpu_gnt  out  1  CPU access performed this cycle.
- cpu_rdata / cpu_rvld  out  DATA_W / 1  CPU read data and its valid.
- dbg_req / dbg_wr / dbg_lock  in  1 / 1 / 1  debug request, write select, and lock hold.
- dbg_addr / dbg_wdata  in  ADDR_W / DATA_W  debug address and write data.
- dbg_gnt  out  1  debug access performed this cycle.
- dbg_rdata / dbg_rvld  out  DATA_W / 1  debug read data and its valid.
- mem_en / mem_rd / mem_wr  out  1 / 1 / 1  memory strobes.
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and write data.
- mem_rdata  in  DATA_W  synchronous-read memory data, valid one cycle after mem_rd.
- lock_active  out  1  FSM is in LOCK.

## Operation
- FSM has 2 states, ARB and LOCK; reset state is ARB.
- In ARB, the CPU wins if cpu_req=1 and NOT (dbg_req=1 and starve_cnt==STARVE_LIMIT). Otherwise dbg wins if dbg_req=1. Otherwise the cycle is idle.
- ARB→LOCK when dbg is granted with dbg_lock=1.
- In LOCK, cpu_gnt=0 always. dbg_gnt=dbg_req. The state stays LOCK while dbg_lock=1 and goes LOCK→ARB the cycle after dbg_lock=0 is sampled; the exit cycle itself still arbitrates as LOCK.
- starve_cnt is 4 bits:
  - +1 when dbg_req=1 and cpu_gnt=1, saturating at STARVE_LIMIT.
  - Cleared on dbg_gnt=1 or dbg_req=0.
  - Held in LOCK.
- Memory strobes are driven from the winning requester's fields:
  - mem_en = cpu_gnt | dbg_gnt.
  - mem_rd = mem_en & ~winner_wr.
  - mem_wr = mem_en & winner_wr.
  - mem_addr and mem_wdata are zero when idle.
- Read return:
  - A 2-bit rd_owner_q register records {dbg, cpu} read grants.
  - cpu_rvld = rd_owner_q[0], dbg_rvld = rd_owner_q[1].
  - cpu_rdata and dbg_rdata equal mem_rdata when their own valid is set, else 0.
- Write grants produce no rvld.
- Requesters hold their request and fields until granted. A request deasserted before grant is simply dropped.

## Timing
- Grants and mem_* are combinational from the current request and registered state, so a granted access has zero added latency.
- Read data returns 1 cycle after grant, in the same cycle as the memory's registered read.
- Back-to-back reads from alternating owners each get their own rvld on consecutive cycles.
- Reset values:
  - cpu_gnt, dbg_gnt, mem_en, mem_rd, mem_wr, cpu_rvld, dbg_rvld, lock_active are 0.
  - rdata and mem_addr/mem_wdata are 0 when no request is present.
  - FSM is ARB, starve_cnt is 0, rd_owner_q is 0.
- Reset asserted mid-operation clears any pending rvld immediately (asynchronous). A read granted in the cycle before reset never reports valid.
- Both requesters present with dbg_lock=1 and CPU not starved-out: the CPU wins and LOCK is not entered. starve_cnt increments.
- A single cycle never asserts both grants.

## Structure
- The shared defines header holds:
  - FSM encodings DMEM_ARB=1'b0 and DMEM_LOCK=1'b1.
  - Owner bit positions OWN_CPU=0 and OWN_DBG=1.
  - The default STARVE_LIMIT.
- One sub-module, dmem_starve_ctr: a saturating counter with inc, clr, hold and limit-reached outputs, parameterised by STARVE_LIMIT.
- The FSM, grant logic, mux and rd_owner_q stay in dmem_arbiter.

## Test plan
- CPU-only read: cpu_req=1, cpu_wr=0, cpu_addr=12'h0A5, mem returns 8'h3C → cpu_gnt=1 and mem_rd=1 in cycle N; cpu_rvld=1 and cpu_rdata=8'h3C in cycle N+1; dbg_rvld stays 0.
- Starvation: cpu_req and dbg_req held high from cycle 0 with STARVE_LIMIT=4 → cpu_gnt in cycles 0–3, dbg_gnt in cycle 4, cpu_gnt again from cycle 5.
- Lock: with only dbg_req=1 and dbg_lock=1 for 3 cycles, then dbg_lock=0, while cpu_req=1 throughout → lock_active=1 for cycles 1–3, cpu_gnt=0 through cycle 3, cpu_gnt=1 in cycle 4.
- Simultaneous requests with dbg_lock=1 and starve_cnt=0 → CPU granted, lock_active stays 0, starve_cnt=1.
- Debug write dbg_addr=12'hFFF, dbg_wdata=8'h81 → mem_wr=1 with those values; no rvld in the next cycle.
- Reset mid-read: CPU read granted in cycle N, reset_ low in cycle N+1 → cpu_rvld=0, all outputs 0, FSM ARB; after release, the next CPU request is granted normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice.
//   dmem_state_e       : arbiter FSM encoding (DMEM_ARB / DMEM_LOCK)
//   OWN_CPU / OWN_DBG  : bit positions inside the read-owner register
//   DMEM_STARVE_LIMIT  : default number of cycles a debug request may lose
//   STARVE_CNT_W       : width of the starvation counter
package dmem_arbiter_pkg;

    typedef enum logic {
        DMEM_ARB  = 1'b0,
        DMEM_LOCK = 1'b1
    } dmem_state_e;

    localparam int OWN_CPU = 0;
    localparam int OWN_DBG = 1;

    localparam int DMEM_STARVE_LIMIT = 4;
    localparam int STARVE_CNT_W      = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the CPU request port, the debug/loader request port and the
// single-ported data memory port seen by the arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants/strobes)
//   master : environment view (requesters and memory)
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) ();

    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvld;

    logic              dbg_req;
    logic              dbg_wr;
    logic              dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvld;

    logic              mem_en;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata, cpu_rvld,
        input  dbg_req, dbg_wr, dbg_lock, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rdata, dbg_rvld,
        output mem_en, mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata, cpu_rvld,
        output dbg_req, dbg_wr, dbg_lock, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rdata, dbg_rvld,
        input  mem_en, mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// dmem_starve_ctr
// Saturating count of consecutive cycles a pending debug request lost to
// the CPU.
//   clk, reset_ : clock, asynchronous active-low reset
//   inc         : debug lost this cycle (saturates at STARVE_LIMIT)
//   clr         : debug granted or no longer requesting
//   hold        : freeze the count (arbiter in LOCK); wins over clr/inc
//   cnt         : current count
//   limit_hit   : count has reached STARVE_LIMIT
module dmem_starve_ctr
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic                    inc,
    input  logic                    clr,
    input  logic                    hold,
    output logic [STARVE_CNT_W-1:0] cnt,
    output logic                    limit_hit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt <= '0;
        end else if (hold) begin
            cnt <= cnt;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign limit_hit = (cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-ported data memory between the execute unit (CPU,
// fixed priority) and the debug/loader port. The debug port cannot lose
// more than STARVE_LIMIT cycles in a row, and can hold the memory across
// several cycles with dbg_lock. Read data comes back one cycle after the
// grant, qualified by a registered valid for the requester that read.
//   clk, reset_ : clock, asynchronous active-low reset
//   bus         : CPU port, debug port and memory port (slave modport)
//   lock_active : arbiter is in LOCK
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8
) (
    input  logic           clk,
    input  logic           reset_,
    dmem_arbiter_if.slave  bus,
    output logic           lock_active
);

    dmem_state_e             state_q;
    dmem_state_e             state_d;
    logic                    cpu_gnt;
    logic                    dbg_gnt;
    logic                    win_wr;
    logic [ADDR_W-1:0]       win_addr;
    logic [DATA_W-1:0]       win_wdata;
    logic [1:0]              rd_owner_q;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    starve_hit;

    dmem_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset_   (reset_),
        .inc      (bus.dbg_req & cpu_gnt),
        .clr      (dbg_gnt | ~bus.dbg_req),
        .hold     (state_q == DMEM_LOCK),
        .cnt      (starve_cnt),
        .limit_hit(starve_hit)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= DMEM_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // In LOCK the exit cycle (dbg_lock sampled low) is still arbitrated
    // as LOCK; the CPU only sees the memory again on the following cycle.
    always_comb begin
        state_d = state_q;
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        case (state_q)
            DMEM_ARB: begin
                cpu_gnt = bus.cpu_req && !(bus.dbg_req && starve_hit);
                dbg_gnt = !cpu_gnt && bus.dbg_req;
                if (dbg_gnt && bus.dbg_lock) begin
                    state_d = DMEM_LOCK;
                end
            end
            DMEM_LOCK: begin
                dbg_gnt = bus.dbg_req;
                if (!bus.dbg_lock) begin
                    state_d = DMEM_ARB;
                end
            end
            default: begin
                state_d = DMEM_ARB;
            end
        endcase
    end

    // Winner's fields steer the memory; everything is zero when idle.
    always_comb begin
        win_wr    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (cpu_gnt) begin
            win_wr    = bus.cpu_wr;
            win_addr  = bus.cpu_addr;
            win_wdata = bus.cpu_wdata;
        end else if (dbg_gnt) begin
            win_wr    = bus.dbg_wr;
            win_addr  = bus.dbg_addr;
            win_wdata = bus.dbg_wdata;
        end
    end

    // Remembers who issued this cycle's read so the returning data is
    // delivered to that requester only; writes leave no owner.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_owner_q <= '0;
        end else begin
            rd_owner_q[OWN_CPU] <= cpu_gnt & ~bus.cpu_wr;
            rd_owner_q[OWN_DBG] <= dbg_gnt & ~bus.dbg_wr;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.dbg_gnt   = dbg_gnt;
    assign bus.mem_en    = cpu_gnt | dbg_gnt;
    assign bus.mem_rd    = (cpu_gnt | dbg_gnt) & ~win_wr;
    assign bus.mem_wr    = (cpu_gnt | dbg_gnt) & win_wr;
    assign bus.mem_addr  = win_addr;
    assign bus.mem_wdata = win_wdata;

    assign bus.cpu_rvld  = rd_owner_q[OWN_CPU];
    assign bus.dbg_rvld  = rd_owner_q[OWN_DBG];
    assign bus.cpu_rdata = rd_owner_q[OWN_CPU] ? bus.mem_rdata : '0;
    assign bus.dbg_rdata = rd_owner_q[OWN_DBG] ? bus.mem_rdata : '0;

    assign lock_active   = (state_q == DMEM_LOCK);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed scoreboard bench for dmem_arbiter. Stimulus pushes the expected
// grant (and, for reads, the expected read return) tagged with the cycle it
// must appear in; a negedge monitor pops and compares whenever the DUT
// shows a grant or a read valid.
module tb_dmem_arbiter;

    logic       clk;
    logic       reset_;
    logic       lock_active;
    int         cycleNum;
    int         compared;
    int         mismatched;
    logic [7:0] mem [4096];

    logic [39:0] grantQ [$];
    logic [33:0] rvldQ  [$];

    dmem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    dmem_arbiter #(
        .STARVE_LIMIT(4),
        .ADDR_W      (12),
        .DATA_W      (8)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .bus        (bus),
        .lock_active(lock_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cycleNum   = 0;
        compared   = 0;
        mismatched = 0;
    end

    always @(posedge clk) cycleNum <= cycleNum + 1;

    // Preset memory contents used by the directed reads.
    function automatic logic [7:0] presetData(input int a);
        case (a)
            12'h0A5: presetData = 8'h3C;
            12'h010: presetData = 8'h11;
            12'h020: presetData = 8'h22;
            12'h030: presetData = 8'h33;
            default: presetData = 8'h00;
        endcase
    endfunction

    // Synchronous-read memory model; reset reloads the presets.
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < 4096; i++) mem[i] <= presetData(i);
            bus.mem_rdata <= 8'h00;
        end else begin
            if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
            if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [39:0] actual,
                               input logic [39:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)",
                     name, actual, expected, cycleNum);
        end
    endtask

    // Monitor: compares every grant and every read return against the queues.
    always @(negedge clk) begin
        if (reset_) begin
            if (bus.cpu_gnt || bus.dbg_gnt) begin
                checkOutput("single_grant", 40'(bus.cpu_gnt & bus.dbg_gnt), 40'd0);
                if (grantQ.size() == 0) begin
                    checkOutput("grant_unexpected", 40'd1, 40'd0);
                end else begin
                    checkOutput("grant",
                        {16'(cycleNum), bus.dbg_gnt, bus.mem_rd, bus.mem_wr,
                         bus.mem_addr, bus.mem_wdata, lock_active},
                        grantQ.pop_front());
                end
            end
            if (bus.cpu_rvld || bus.dbg_rvld) begin
                if (rvldQ.size() == 0) begin
                    checkOutput("rvld_unexpected", 40'd1, 40'd0);
                end else begin
                    checkOutput("read_return",
                        40'({16'(cycleNum), bus.dbg_rvld, bus.cpu_rvld,
                             bus.cpu_rdata, bus.dbg_rdata}),
                        40'(rvldQ.pop_front()));
                end
            end
        end
    end

    // Drive one cycle of requests; expWho 0=idle, 1=CPU, 2=debug wins.
    task automatic applyStimulus(
        input logic cReq, input logic cWr, input logic [11:0] cAddr, input logic [7:0] cWd,
        input logic dReq, input logic dWr, input logic dLock,
        input logic [11:0] dAddr, input logic [7:0] dWd,
        input int expWho, input logic expLock, input logic [7:0] expData, input bit expRet);
        @(posedge clk);
        #1;
        bus.cpu_req   = cReq;
        bus.cpu_wr    = cWr;
        bus.cpu_addr  = cAddr;
        bus.cpu_wdata = cWd;
        bus.dbg_req   = dReq;
        bus.dbg_wr    = dWr;
        bus.dbg_lock  = dLock;
        bus.dbg_addr  = dAddr;
        bus.dbg_wdata = dWd;
        if (expWho == 1) begin
            grantQ.push_back({16'(cycleNum), 1'b0, ~cWr, cWr, cAddr, cWd, expLock});
            if (!cWr && expRet)
                rvldQ.push_back({16'(cycleNum + 1), 1'b0, 1'b1, expData, 8'h00});
        end else if (expWho == 2) begin
            grantQ.push_back({16'(cycleNum), 1'b1, ~dWr, dWr, dAddr, dWd, expLock});
            if (!dWr && expRet)
                rvldQ.push_back({16'(cycleNum + 1), 1'b1, 1'b0, 8'h00, expData});
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 12'h0, 8'h0, 0, 0, 0, 12'h0, 8'h0, 0, 0, 8'h0, 0);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_strobes"},
            40'({bus.cpu_gnt, bus.dbg_gnt, bus.mem_en, bus.mem_rd, bus.mem_wr}), 40'd0);
        checkOutput({tag, "_rvld"},
            40'({bus.cpu_rvld, bus.dbg_rvld, bus.cpu_rdata, bus.dbg_rdata}), 40'd0);
        checkOutput({tag, "_bus"}, 40'({bus.mem_addr, bus.mem_wdata}), 40'd0);
        checkOutput({tag, "_state"},
            40'({lock_active, dut.state_q, dut.u_starve.cnt, dut.rd_owner_q}), 40'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_        = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = 12'h0;
        bus.cpu_wdata = 8'h0;
        bus.dbg_req   = 1'b0;
        bus.dbg_wr    = 1'b0;
        bus.dbg_lock  = 1'b0;
        bus.dbg_addr  = 12'h0;
        bus.dbg_wdata = 8'h0;

        repeat (2) @(negedge clk);
        checkQuiet("reset");
        reset_ = 1'b1;

        // CPU-only read of 0A5 returns 3C one cycle later.
        $display("[TB] cpu-only read");
        applyStimulus(1, 0, 12'h0A5, 8'h00, 0, 0, 0, 12'h0, 8'h0, 1, 0, 8'h3C, 1);
        idleCycle();

        // Both requesting: CPU x4, debug once, CPU again.
        $display("[TB] starvation limit");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 12'h010, 8'h00, 1, 0, 0, 12'h020, 8'h00,
                          (i == 4) ? 2 : 1, 0, (i == 4) ? 8'h22 : 8'h11, 1);
        end
        idleCycle();

        // Lock: debug read, two locked writes, exit-cycle read, then CPU.
        $display("[TB] debug lock");
        applyStimulus(0, 0, 12'h0A5, 8'h00, 1, 0, 1, 12'h030, 8'h00, 2, 0, 8'h33, 1);
        applyStimulus(1, 0, 12'h0A5, 8'h00, 1, 1, 1, 12'h031, 8'h5A, 2, 1, 8'h00, 1);
        applyStimulus(1, 0, 12'h0A5, 8'h00, 1, 1, 1, 12'h031, 8'h5A, 2, 1, 8'h00, 1);
        applyStimulus(1, 0, 12'h0A5, 8'h00, 1, 0, 0, 12'h031, 8'h00, 2, 1, 8'h5A, 1);
        applyStimulus(1, 0, 12'h0A5, 8'h00, 0, 0, 0, 12'h0,   8'h00, 1, 0, 8'h3C, 1);
        idleCycle();

        // Simultaneous requests with dbg_lock and an empty starve count.
        $display("[TB] simultaneous with lock");
        applyStimulus(1, 0, 12'h0A5, 8'h00, 1, 0, 1, 12'h040, 8'h00, 1, 0, 8'h3C, 1);
        idleCycle();
        @(negedge clk);
        checkOutput("simul_lock_active", 40'(lock_active), 40'd0);
        checkOutput("simul_starve_cnt", 40'(dut.u_starve.cnt), 40'd1);
        idleCycle();

        // Debug write to the top address, then read it back.
        $display("[TB] debug write");
        applyStimulus(0, 0, 12'h0, 8'h00, 1, 1, 0, 12'hFFF, 8'h81, 2, 0, 8'h00, 1);
        idleCycle();
        @(negedge clk);
        checkOutput("write_no_rvld", 40'({bus.cpu_rvld, bus.dbg_rvld}), 40'd0);
        applyStimulus(0, 0, 12'h0, 8'h00, 1, 0, 0, 12'hFFF, 8'h00, 2, 0, 8'h81, 1);
        idleCycle();

        // Reset arrives the cycle after a CPU read grant.
        $display("[TB] reset mid-read");
        applyStimulus(1, 0, 12'h0A5, 8'h00, 0, 0, 0, 12'h0, 8'h0, 1, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        reset_      = 1'b0;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        checkQuiet("midreset");
        @(negedge clk);
        reset_ = 1'b1;
        applyStimulus(1, 0, 12'h0A5, 8'h00, 0, 0, 0, 12'h0, 8'h0, 1, 0, 8'h3C, 1);
        idleCycle();
        idleCycle();
        idleCycle();

        @(negedge clk);
        checkOutput("grant_queue_drained", 40'(grantQ.size()), 40'd0);
        checkOutput("rvld_queue_drained", 40'(rvldQ.size()), 40'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
